router_switch_ctrl: RTL and testbench
=====================================

# router_switch_ctrl

Switch controller for the 5-port credit-based mesh router. It arbitrates round-robin among input buffers that present a packet header and computes the XY output port for the winner. It grants the connection when that output is free, drives the crossbar selects and releases output ports when the owning input finishes its packet. It sits between the five input buffers (h/ack_h/sender handshake) and the crossbar (mux_in/mux_out/free).

## Interface
Parameters:
- NPORT, 5: number of ports; indices EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- TAM_FLIT, 16: flit width.
- METADEFLIT, 8: router address width; X in [7:4], Y in [3:0].

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- address  in  METADEFLIT  this router's XY address, static.
- h  in  NPORT  input i has a header flit at its buffer head.
- data  in  NPORT x TAM_FLIT  head flit of each input buffer; target XY in bits [7:0].
- sender  in  NPORT  input i is forwarding a packet; high from ack until the tail flit leaves.
- ack_h  out  NPORT  one-cycle grant pulse to the winning input; one-hot or zero.
- free  out  NPORT  output o is unallocated.
- mux_in  out  NPORT x 3  output index selected by input i.
- mux_out  out  NPORT x 3  input index driving output o.

## Operation
- FSM states: S_IDLE, S_ARB, S_ROUTE, S_GRANT.
- S_IDLE: if |h, go to S_ARB; otherwise stay.
- S_ARB: round-robin pick.
  - Search order starts at (last+1) mod NPORT over h; the first set bit becomes sel.
  - last is updated to sel.
  - If h has dropped to 0, return to S_IDLE.
  - Go to S_ROUTE.
- S_ROUTE: XY routing on data[sel][7:0] against address.
  - tx > lx gives EAST; tx < lx gives WEST.
  - Otherwise ty > ly gives NORTH; ty < ly gives SOUTH.
  - Otherwise LOCAL.
  - Comparisons are unsigned 4-bit.
  - If free[out]=1, go to S_GRANT. Else go to S_IDLE; the request is retried and last=sel gives other requesters priority.
- S_GRANT: one cycle.
  - ack_h[sel]=1.
  - mux_in[sel]<=out, mux_out[out]<=sel, free[out]<=0.
  - Next state S_IDLE.
- Release runs in parallel with the FSM every cycle.
  - sender is registered into sender_q.
  - For each o with free[o]=0: if sender_q[mux_out[o]]=1 and sender[mux_out[o]]=0 (falling edge), then free[o]<=1 next cycle.
- Simultaneous grant and release on different outputs: both take effect.
- A grant never targets a busy output, so grant and release cannot hit the same o.
- A request to the router's own output for a U-turn (e.g. EAST in, EAST out) is legal; XY never produces it from valid traffic, and it is not checked.

## Timing
- Reset, asynchronous active-low:
  - state=S_IDLE, last=LOCAL (first search starts at EAST).
  - ack_h=0, free=all 1, mux_in=mux_out=0, sender_q=0.
- Latency: h seen high in S_IDLE in cycle t gives ack_h high in cycle t+3 when the output is free.
- Minimum spacing between two grants is 4 cycles.
- ack_h is high exactly one cycle and is never asserted for an input with h=0 at S_ARB.
- free[o] rises one cycle after the sender falling edge; a new grant to o is possible in the following S_ROUTE.
- Reset asserted mid-operation aborts any grant. All connections are dropped and all outputs are free after deassertion.

## Structure
- Package hemps_defaults holds:
  - NPORT, TAM_FLIT, METADEFLIT, QUARTOFLIT.
  - Port index constants.
  - Typedefs regNport, regflit, regmetadeflit, reg3, arrayNport_regflit, arrayNport_reg3.
  - The FSM state enum.
- Sub-module rr_arbiter (NPORT requests plus last pointer in; one-hot grant and index out) is combinational and separately unit-tested.
- The XY router is a function in this module.

## Test plan
- Single request: address=8'h11, h=5'b00001 (EAST), data[0][7:0]=8'h11 -> LOCAL; ack_h=5'b00001 at t+3; mux_out[4]=0, mux_in[0]=4, free[4]=0.
- Round-robin: after reset, h=5'b11111 held, all targets distinct -> grants in order EAST, WEST, NORTH, SOUTH, LOCAL, 4 cycles apart.
- Contention: EAST and WEST inputs both target NORTH (data=8'h12, address=8'h11) -> EAST granted first; WEST retries with no ack; sender[0] falls -> free[2]=1 next cycle -> WEST acked.
- XY decode: address=8'h22; targets 8'h32, 8'h12, 8'h23, 8'h21, 8'h22 -> EAST, WEST, NORTH, SOUTH, LOCAL respectively.
- Release/grant overlap: release of SOUTH in the same cycle as a grant of WEST -> both outputs updated and ack_h one-hot.
- Reset mid-grant: reset low during S_ROUTE -> ack_h stays 0, free=5'b11111, state S_IDLE after release.

Source files
------------

// File: rtl/router_switch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : hemps_defaults
// Shared constants, port indices, types and FSM encoding for the switch ctrl.
// Rev    : 1.0
// ============================================================================
package hemps_defaults;

  localparam int NPORT      = 5;
  localparam int TAM_FLIT   = 16;
  localparam int METADEFLIT = 8;
  localparam int QUARTOFLIT = 4;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  typedef logic [NPORT-1:0]      regNport;
  typedef logic [TAM_FLIT-1:0]   regflit;
  typedef logic [METADEFLIT-1:0] regmetadeflit;
  typedef logic [2:0]            reg3;
  typedef regflit [NPORT-1:0]    arrayNport_regflit;
  typedef reg3 [NPORT-1:0]       arrayNport_reg3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ROUTE = 2'd2,
    S_GRANT = 2'd3
  } sw_state_t;

  // Port index successor with wrap-around at NPORT.
  function automatic reg3 next_port(input reg3 p);
    return (p == reg3'(NPORT - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_switch_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin pick; search begins one past the last winner.
// Rev    : 1.0
// ============================================================================
module rr_arbiter
  import hemps_defaults::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [2:0]       last,
  output logic [NPORT-1:0] grant,
  output logic [2:0]       idx,
  output logic             valid
);

  logic [2:0] w_probe;

  always_comb begin
    grant   = '0;
    idx     = last;
    valid   = 1'b0;
    w_probe = last;
    for (int i = 0; i < NPORT; i++) begin
      w_probe = next_port(w_probe);
      if (!valid && req[w_probe]) begin
        valid          = 1'b1;
        idx            = w_probe;
        grant[w_probe] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : router_switch_ctrl
// Round-robin header arbitration, XY routing, crossbar allocation and release.
// Rev    : 1.0
// ============================================================================
module router_switch_ctrl #(
  parameter int NPORT      = hemps_defaults::NPORT,
  parameter int TAM_FLIT   = hemps_defaults::TAM_FLIT,
  parameter int METADEFLIT = hemps_defaults::METADEFLIT
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [METADEFLIT-1:0]            address,
  input  logic [NPORT-1:0]                 h,
  input  logic [NPORT-1:0][TAM_FLIT-1:0]   data,
  input  logic [NPORT-1:0]                 sender,
  output logic [NPORT-1:0]                 ack_h,
  output logic [NPORT-1:0]                 free,
  output logic [NPORT-1:0][2:0]            mux_in,
  output logic [NPORT-1:0][2:0]            mux_out
);

  import hemps_defaults::*;

  sw_state_t        r_state;
  logic [2:0]       r_last;
  logic [2:0]       r_sel;
  logic [NPORT-1:0] r_sel_oh;
  logic [2:0]       r_out;
  logic [NPORT-1:0] r_sender_q;

  logic [NPORT-1:0] w_arb_grant;
  logic [2:0]       w_arb_idx;
  logic             w_arb_valid;
  logic [2:0]       w_route;
  logic [NPORT-1:0] w_release;
  logic             w_unused_data;

  // Only the address byte of the head flit matters here.
  assign w_unused_data = ^data;

  function automatic logic [2:0] xy_route(input logic [METADEFLIT-1:0] here,
                                          input logic [METADEFLIT-1:0] dest);
    logic [QUARTOFLIT-1:0] lx, ly, tx, ty;
    lx = here[METADEFLIT-1:QUARTOFLIT];
    ly = here[QUARTOFLIT-1:0];
    tx = dest[METADEFLIT-1:QUARTOFLIT];
    ty = dest[QUARTOFLIT-1:0];
    if (tx > lx)      return EAST;
    else if (tx < lx) return WEST;
    else if (ty > ly) return NORTH;
    else if (ty < ly) return SOUTH;
    else              return LOCAL;
  endfunction

  rr_arbiter u_arb (
    .req   (h),
    .last  (r_last),
    .grant (w_arb_grant),
    .idx   (w_arb_idx),
    .valid (w_arb_valid)
  );

  assign w_route = xy_route(address, data[r_sel][METADEFLIT-1:0]);

  // An allocated output frees up when its owning input's sender falls.
  always_comb begin
    w_release = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (!free[o] && r_sender_q[mux_out[o]] && !sender[mux_out[o]]) begin
        w_release[o] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= LOCAL;
      r_sel      <= 3'd0;
      r_sel_oh   <= '0;
      r_out      <= 3'd0;
      r_sender_q <= '0;
      ack_h      <= '0;
      free       <= '1;
      mux_in     <= '0;
      mux_out    <= '0;
    end else begin
      r_sender_q <= sender;
      ack_h      <= '0;
      free       <= free | w_release;
      case (r_state)
        S_IDLE: begin
          if (|h) r_state <= S_ARB;
        end
        S_ARB: begin
          if (!w_arb_valid) begin
            r_state <= S_IDLE;
          end else begin
            r_sel    <= w_arb_idx;
            r_sel_oh <= w_arb_grant;
            r_last   <= w_arb_idx;
            r_state  <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          r_out <= w_route;
          if (free[w_route]) begin
            ack_h   <= r_sel_oh;
            r_state <= S_GRANT;
          end else begin
            // Busy output: retry later; r_last already favours the others.
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          mux_in[r_sel]  <= r_out;
          mux_out[r_out] <= r_sel;
          free[r_out]    <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_router_switch_ctrl
// Directed scenarios plus randomized traffic against a timeline reference model.
// Rev    : 1.0
// ============================================================================
module tb_router_switch_ctrl;

  localparam int NP = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [7:0]           address;
  logic [NP-1:0]        h;
  logic [NP-1:0][15:0]  data;
  logic [NP-1:0]        sender;
  logic [NP-1:0]        ack_h;
  logic [NP-1:0]        free;
  logic [NP-1:0][2:0]   mux_in;
  logic [NP-1:0][2:0]   mux_out;

  int checks = 0;
  int errors = 0;

  router_switch_ctrl #(.NPORT(5), .TAM_FLIT(16), .METADEFLIT(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .h       (h),
    .data    (data),
    .sender  (sender),
    .ack_h   (ack_h),
    .free    (free),
    .mux_in  (mux_in),
    .mux_out (mux_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    h = '0; sender = '0; data = '0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  // XY decision from the routing rules: 0=E 1=W 2=N 3=S 4=L.
  function automatic int ref_route(input int here, input int dest);
    int lx, ly, tx, ty;
    lx = here / 16; ly = here % 16; tx = dest / 16; ty = dest % 16;
    if (tx > lx) return 0;
    if (tx < lx) return 1;
    if (ty > ly) return 2;
    if (ty < ly) return 3;
    return 4;
  endfunction

  task automatic test_reset();
    address = 8'h11; h = '0; sender = '0; data = '0;
    reset = 1'b0;
    step();
    checks++; if (ack_h !== 5'b0) begin errors++; $display("FAIL reset_ack got %b want %b", ack_h, 5'b0); end
    checks++; if (free !== 5'h1f) begin errors++; $display("FAIL reset_free got %b want %b", free, 5'h1f); end
    checks++; if (mux_in !== 15'b0) begin errors++; $display("FAIL reset_mux_in got %h want 0", mux_in); end
    checks++; if (mux_out !== 15'b0) begin errors++; $display("FAIL reset_mux_out got %h want 0", mux_out); end
    h = 5'h1f;
    step(); step();
    checks++; if (ack_h !== 5'b0 || free !== 5'h1f) begin errors++; $display("FAIL reset_hold ack %b free %b want 0/11111", ack_h, free); end
    h = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] exp;
    do_reset();
    address = 8'h11; data[0] = 16'hA511; h = 5'b00001;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = (k == 3) ? 5'b00001 : 5'b00000;
      checks++; if (ack_h !== exp) begin errors++; $display("FAIL single_ack cyc %0d got %b want %b", k, ack_h, exp); end
    end
    h = '0; sender = 5'b00001;
    step();
    checks++; if (mux_in[0] !== 3'd4) begin errors++; $display("FAIL single_mux_in got %0d want 4", mux_in[0]); end
    checks++; if (mux_out[4] !== 3'd0) begin errors++; $display("FAIL single_mux_out got %0d want 0", mux_out[4]); end
    checks++; if (free !== 5'b01111 || ack_h !== 5'b0) begin errors++; $display("FAIL single_free free %b ack %b want 01111/0", free, ack_h); end
    sender = '0;
    step();
    checks++; if (free !== 5'h1f) begin errors++; $display("FAIL single_release got %b want 11111", free); end
  endtask

  task automatic test_round_robin();
    logic [7:0] tgt [5];
    logic [4:0] exp;
    tgt[0] = 8'h21; tgt[1] = 8'h01; tgt[2] = 8'h12; tgt[3] = 8'h10; tgt[4] = 8'h11;
    do_reset();
    address = 8'h11;
    for (int i = 0; i < NP; i++) data[i] = {8'($urandom), tgt[(i + 1) % NP]};
    h = 5'h1f;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = (k >= 3 && (k - 3) % 4 == 0) ? 5'(1 << ((k - 3) / 4)) : 5'b0;
      checks++; if (ack_h !== exp) begin errors++; $display("FAIL rr_ack cyc %0d got %b want %b", k, ack_h, exp); end
    end
    checks++; if (free !== 5'b0) begin errors++; $display("FAIL rr_free got %b want 00000", free); end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (mux_out[(i + 1) % NP] !== 3'(i) || mux_in[i] !== 3'((i + 1) % NP)) begin
        errors++; $display("FAIL rr_mux in %0d mux_in %0d mux_out %0d", i, mux_in[i], mux_out[(i + 1) % NP]);
      end
    end
    h = '0;
  endtask

  task automatic test_contention();
    bit found;
    do_reset();
    address = 8'h11; data[0] = 16'h0012; data[1] = 16'h3412; h = 5'b00011;
    step(); step(); step();
    checks++; if (ack_h !== 5'b00001) begin errors++; $display("FAIL cont_first got %b want 00001", ack_h); end
    h = 5'b00010; sender = 5'b00001;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (ack_h !== 5'b0 || free[2] !== 1'b0) begin errors++; $display("FAIL cont_blocked cyc %0d ack %b free %b", k, ack_h, free); end
    end
    sender = '0;
    step();
    checks++; if (free !== 5'h1f || ack_h !== 5'b0) begin errors++; $display("FAIL cont_release free %b ack %b want 11111/0", free, ack_h); end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (ack_h !== 5'b0) found = 1'b1;
    end
    checks++; if (!found || ack_h !== 5'b00010) begin errors++; $display("FAIL cont_retry got %b want 00010", ack_h); end
    h = '0; sender = 5'b00010;
    step();
    checks++; if (mux_out[2] !== 3'd1 || mux_in[1] !== 3'd2 || free !== 5'b11011) begin
      errors++; $display("FAIL cont_mux mux_out2 %0d mux_in1 %0d free %b want 1/2/11011", mux_out[2], mux_in[1], free);
    end
    sender = '0;
  endtask

  task automatic test_xy_decode();
    logic [7:0] tgt [5];
    int exp_out [5];
    int src;
    logic [4:0] oh;
    tgt[0] = 8'h32; tgt[1] = 8'h12; tgt[2] = 8'h23; tgt[3] = 8'h21; tgt[4] = 8'h22;
    exp_out[0] = 0; exp_out[1] = 1; exp_out[2] = 2; exp_out[3] = 3; exp_out[4] = 4;
    for (int k = 0; k < 5; k++) begin
      do_reset();
      address = 8'h22;
      src = int'($urandom_range(0, 4));
      oh = 5'(1 << src);
      data[src] = {8'($urandom), tgt[k]};
      h = oh;
      step(); step();
      checks++; if (ack_h !== 5'b0) begin errors++; $display("FAIL xy_early tgt %h got %b want 0", tgt[k], ack_h); end
      step();
      checks++; if (ack_h !== oh) begin errors++; $display("FAIL xy_ack tgt %h got %b want %b", tgt[k], ack_h, oh); end
      h = '0;
      step();
      checks++;
      if (mux_in[src] !== 3'(exp_out[k]) || free !== (5'h1f & ~5'(1 << exp_out[k]))) begin
        errors++; $display("FAIL xy_route tgt %h mux_in %0d free %b want %0d", tgt[k], mux_in[src], free, exp_out[k]);
      end
    end
  endtask

  task automatic test_overlap();
    do_reset();
    address = 8'h11; data[4] = 16'h0010; h = 5'b10000;
    step(); step(); step();
    checks++; if (ack_h !== 5'b10000) begin errors++; $display("FAIL ov_first got %b want 10000", ack_h); end
    h = '0; sender = 5'b10000;
    step(); step();
    data[1] = 16'h0001; h = 5'b00010;
    step(); step(); step();
    checks++; if (ack_h !== 5'b00010) begin errors++; $display("FAIL ov_ack got %b want 00010", ack_h); end
    sender = '0; h = '0;
    step();
    checks++; if (free !== 5'b11101) begin errors++; $display("FAIL ov_free got %b want 11101", free); end
    checks++; if (mux_out[1] !== 3'd1 || mux_in[1] !== 3'd1 || ack_h !== 5'b0) begin
      errors++; $display("FAIL ov_mux mux_out1 %0d mux_in1 %0d ack %b", mux_out[1], mux_in[1], ack_h);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp;
    do_reset();
    address = 8'h11; data[2] = 16'h0021; h = 5'b00100;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (ack_h !== 5'b0 || free !== 5'h1f) begin errors++; $display("FAIL mid_async ack %b free %b", ack_h, free); end
    step();
    checks++; if (ack_h !== 5'b0 || mux_in !== 15'b0 || mux_out !== 15'b0) begin errors++; $display("FAIL mid_hold ack %b mux_in %h mux_out %h", ack_h, mux_in, mux_out); end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = (k == 3) ? 5'b00100 : 5'b0;
      checks++; if (ack_h !== exp) begin errors++; $display("FAIL mid_restart cyc %0d got %b want %b", k, ack_h, exp); end
    end
    h = '0;
  endtask

  // Timeline model: the controller sits idle until it sees a request, picks
  // one cycle later, checks the route the cycle after, and acks the next.
  task automatic test_random(input int ncyc);
    int resume_at, pick_at, route_at, ack_at, ack_sel, ack_out, m_last, m_sel, m_out, p;
    int owner [NP];
    int st [NP];
    int cnt [NP];
    logic [NP-1:0] m_free, nf, prev_sender, exp_ack, nh, ns;
    logic [NP-1:0][15:0] nd;
    logic [3:0] tx, ty;
    bit found;
    address = 8'($urandom);
    do_reset();
    m_free = '1; prev_sender = '0; m_last = 4;
    resume_at = 0; pick_at = -1; route_at = -1; ack_at = -10;
    ack_sel = 0; ack_out = 0; m_sel = 0; m_out = 0;
    for (int i = 0; i < NP; i++) begin owner[i] = -1; st[i] = 0; cnt[i] = 0; end
    for (int t = 0; t < ncyc; t++) begin
      exp_ack = (ack_at == t) ? 5'(1 << ack_sel) : 5'b0;
      checks++; if (ack_h !== exp_ack) begin errors++; $display("FAIL rand_ack t=%0d got %b want %b", t, ack_h, exp_ack); end
      checks++; if (free !== m_free) begin errors++; $display("FAIL rand_free t=%0d got %b want %b", t, free, m_free); end
      if (t == ack_at + 1) begin
        checks++;
        if (mux_in[ack_sel] !== 3'(ack_out) || mux_out[ack_out] !== 3'(ack_sel)) begin
          errors++; $display("FAIL rand_mux t=%0d in %0d out %0d got mux_in %0d mux_out %0d", t, ack_sel, ack_out, mux_in[ack_sel], mux_out[ack_out]);
        end
      end

      nf = m_free;
      for (int o = 0; o < NP; o++)
        if (!m_free[o] && owner[o] >= 0 && prev_sender[owner[o]] && !sender[owner[o]]) nf[o] = 1'b1;
      if (ack_at == t) begin nf[ack_out] = 1'b0; owner[ack_out] = ack_sel; end

      if (route_at == t) begin
        m_out = ref_route(int'(address), int'(data[m_sel][7:0]));
        if (m_free[m_out]) begin
          ack_at = t + 1; ack_sel = m_sel; ack_out = m_out; resume_at = t + 2;
        end else begin
          resume_at = t + 1;
        end
      end else if (pick_at == t) begin
        if (h == '0) begin
          resume_at = t + 1;
        end else begin
          found = 1'b0;
          for (int k = 1; k <= NP; k++) begin
            p = (m_last + k) % NP;
            if (!found && h[p]) begin found = 1'b1; m_sel = p; end
          end
          m_last = m_sel;
          route_at = t + 1;
        end
      end else if (t >= resume_at && h != '0) begin
        pick_at = t + 1;
        resume_at = 1 << 30;
      end
      prev_sender = sender;
      m_free = nf;

      nh = h; ns = sender; nd = data;
      for (int i = 0; i < NP; i++) begin
        case (st[i])
          0: if ($urandom_range(0, 3) == 0) begin
               tx = ($urandom_range(0, 1) != 0) ? address[7:4] : 4'($urandom);
               ty = ($urandom_range(0, 1) != 0) ? address[3:0] : 4'($urandom);
               nd[i] = {8'($urandom), tx, ty};
               nh[i] = 1'b1; st[i] = 1;
             end
          1: if (exp_ack[i]) begin
               nh[i] = 1'b0; ns[i] = 1'b1; cnt[i] = int'($urandom_range(1, 6)); st[i] = 2;
             end
          default: begin
               cnt[i]--;
               if (cnt[i] == 0) begin ns[i] = 1'b0; st[i] = 0; end
             end
        endcase
      end
      step();
      h = nh; sender = ns; data = nd;
    end
    h = '0; sender = '0;
  endtask

  initial begin
    reset = 1'b0; h = '0; sender = '0; data = '0; address = 8'h11;
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_xy_decode();
    test_overlap();
    test_reset_mid();
    test_random(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
